// File: rtl/core_ctrl_fsm.sv
// -----------------------------------------------------------------------------
// core_ctrl_fsm
//
// Multi-cycle sequencer for the Eka single-issue core. Each instruction goes
// through FETCH -> DECODE -> EXEC -> (MEM) -> (WB) -> FETCH. The block runs the
// valid/ready handshakes with instruction and data memory. It also produces the
// PC, instruction-register and register-file write strobes. Illegal opcodes and
// memory requests that wait too long send it to TRAP, where it stays until reset.
//
// Optional build macro: EKA_PERF_CNT_EN
//   Defined   : cycle_count / instret_count performance counters are built.
//   Undefined : both counter ports are tied to 0 and no counter flops exist.
//
// Parameters
//   MEM_TIMEOUT : most cycles a memory request may wait for ready (0 = no limit)
//   CNT_W       : width of the wait counter, must be able to hold MEM_TIMEOUT
//
// Ports
//   clk, reset        : core clock, synchronous active-high reset
//   dec_*             : decoder control outputs for the current instruction
//   branch_taken      : ALU branch comparison result, valid in EXEC
//   imem_ready        : instruction memory returns the word this cycle
//   dmem_ready        : data memory completes the access this cycle
//   imem_req          : instruction fetch request
//   ir_write_en       : load the fetched word into the instruction register
//   dmem_req, dmem_we : data memory request and its write qualifier
//   rf_write_en       : register file write strobe
//   rf_src_mem        : WB data select, 1 = load data, 0 = ALU result
//   pc_write_en       : PC update, one pulse per retired instruction
//   pc_sel_branch     : PC source, 1 = PC+imm, 0 = PC+4
//   state             : current state encoding (FETCH=0 .. TRAP=5)
//   trap, trap_cause  : halted flag and cause (1 illegal opcode, 2 mem timeout)
//   cycle_count       : clock cycles since reset (optional)
//   instret_count     : retired instructions since reset (optional)
// -----------------------------------------------------------------------------
module core_ctrl_fsm #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        dec_legal,
  input  logic        dec_write_en,
  input  logic        dec_mem_read_en,
  input  logic        dec_mem_write_en,
  input  logic        dec_branch_inst,
  input  logic        branch_taken,
  input  logic        imem_ready,
  input  logic        dmem_ready,
  output logic        imem_req,
  output logic        ir_write_en,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic        rf_write_en,
  output logic        rf_src_mem,
  output logic        pc_write_en,
  output logic        pc_sel_branch,
  output logic [2:0]  state,
  output logic        trap,
  output logic [1:0]  trap_cause,
  output logic [31:0] cycle_count,
  output logic [31:0] instret_count
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'd2;

  // When MEM_TIMEOUT is 0 the counter is never advanced and requests wait forever.
  localparam bit               TIMEOUT_EN = (MEM_TIMEOUT != 0);
  localparam logic [CNT_W-1:0] WAIT_LAST  = CNT_W'(MEM_TIMEOUT - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [1:0]       cause_q, cause_d;

  // Raw FSM outputs. They are masked with reset before they reach the ports.
  logic imem_req_c, ir_write_c, dmem_req_c, dmem_we_c;
  logic rf_write_c, rf_src_mem_c, pc_write_c, pc_sel_c;

  // NOTE: sequential state uses non-blocking assignments so all flops sample
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_FETCH;
      wait_cnt_q <= '0;
      cause_q    <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      cause_q    <= cause_d;
    end
  end

  // NOTE: every signal written here gets a default first, so no path can leave
  // one unassigned and infer a latch.
  always_comb begin
    state_d      = state_q;
    wait_cnt_d   = '0;          // cleared whenever a request is not stalling
    cause_d      = cause_q;
    imem_req_c   = 1'b0;
    ir_write_c   = 1'b0;
    dmem_req_c   = 1'b0;
    dmem_we_c    = 1'b0;
    rf_write_c   = 1'b0;
    rf_src_mem_c = 1'b0;
    pc_write_c   = 1'b0;
    pc_sel_c     = 1'b0;

    case (state_q)
      S_FETCH: begin
        imem_req_c = 1'b1;
        if (imem_ready) begin
          ir_write_c = 1'b1;
          state_d    = S_DECODE;
        end else if (TIMEOUT_EN && wait_cnt_q == WAIT_LAST) begin
          state_d = S_TRAP;
          cause_d = CAUSE_TIMEOUT;
        end else if (TIMEOUT_EN) begin
          wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
      end

      S_DECODE: begin
        if (!dec_legal) begin
          state_d = S_TRAP;
          cause_d = CAUSE_ILLEGAL;
        end else begin
          state_d = S_EXEC;
        end
      end

      S_EXEC: begin
        if (dec_mem_read_en || dec_mem_write_en) begin
          state_d = S_MEM;
        end else if (dec_write_en) begin
          state_d = S_WB;
        end else begin
          // Branches retire here. A legal op that writes nothing also retires
          // here and falls through to PC+4.
          pc_write_c = 1'b1;
          pc_sel_c   = dec_branch_inst & branch_taken;
          state_d    = S_FETCH;
        end
      end

      S_MEM: begin
        dmem_req_c = 1'b1;
        dmem_we_c  = dec_mem_write_en;
        if (dmem_ready) begin
          if (dec_mem_read_en) begin
            state_d = S_WB;
          end else begin
            pc_write_c = 1'b1;
            state_d    = S_FETCH;
          end
        end else if (TIMEOUT_EN && wait_cnt_q == WAIT_LAST) begin
          state_d = S_TRAP;
          cause_d = CAUSE_TIMEOUT;
        end else if (TIMEOUT_EN) begin
          wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
      end

      S_WB: begin
        rf_write_c   = dec_write_en;
        rf_src_mem_c = dec_mem_read_en;
        pc_write_c   = 1'b1;
        state_d      = S_FETCH;
      end

      S_TRAP: begin
        state_d = S_TRAP;
      end

      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  // While reset is high, every output reads 0. This drops an in-flight memory
  // request in the same cycle that reset is sampled.
  assign imem_req      = ~reset & imem_req_c;
  assign ir_write_en   = ~reset & ir_write_c;
  assign dmem_req      = ~reset & dmem_req_c;
  assign dmem_we       = ~reset & dmem_we_c;
  assign rf_write_en   = ~reset & rf_write_c;
  assign rf_src_mem    = ~reset & rf_src_mem_c;
  assign pc_write_en   = ~reset & pc_write_c;
  assign pc_sel_branch = ~reset & pc_sel_c;
  assign state         = reset ? 3'd0 : 3'(state_q);
  assign trap          = ~reset & (state_q == S_TRAP);
  assign trap_cause    = reset ? 2'd0 : cause_q;

`ifdef EKA_PERF_CNT_EN
  logic [31:0] cycle_q, instret_q;

  // Both counters freeze in TRAP so a halted core keeps its final counts.
  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_q   <= '0;
      instret_q <= '0;
    end else if (state_q != S_TRAP) begin
      cycle_q <= cycle_q + 32'd1;
      if (pc_write_c) begin
        instret_q <= instret_q + 32'd1;
      end
    end
  end

  assign cycle_count   = reset ? 32'd0 : cycle_q;
  assign instret_count = reset ? 32'd0 : instret_q;
`else
  assign cycle_count   = 32'd0;
  assign instret_count = 32'd0;
`endif

endmodule

// File: doc/core_ctrl_fsm.md
Name: core_ctrl_fsm

Overview:
Multi-cycle sequencer for the Eka single-issue core. It steps every instruction through FETCH, DECODE, EXEC, MEM and WB using the decoder's control outputs. It handles the valid/ready handshakes to instruction and data memory and generates the write strobes for the PC, the instruction register and the register file. It sits between the decoder/ALU datapath and the memory interfaces, and traps on illegal opcodes or memory timeout.

Parameters:
MEM_TIMEOUT, 16, max cycles a memory request may wait for ready before trapping; 0 disables the timeout.
CNT_W, 8, width of the internal wait counter; must hold MEM_TIMEOUT.

Ports:
clk  input  1  core clock
reset  input  1  synchronous, active-high reset
dec_legal  input  1  decoder recognised the opcode (I, R, B, S, load, LUI)
dec_write_en  input  1  instruction writes rd
dec_mem_read_en  input  1  load instruction
dec_mem_write_en  input  1  store instruction
dec_branch_inst  input  1  branch instruction
branch_taken  input  1  ALU branch comparison result, valid in EXEC
imem_ready  input  1  instruction memory accepts/returns the word this cycle
dmem_ready  input  1  data memory completes the access this cycle
imem_req  output  1  instruction fetch request
ir_write_en  output  1  capture the fetched word into the instruction register
dmem_req  output  1  data memory request
dmem_we  output  1  data memory write (store)
rf_write_en  output  1  register file write strobe
rf_src_mem  output  1  WB data select: 1 = load data, 0 = ALU result
pc_write_en  output  1  update PC; one pulse per retired instruction
pc_sel_branch  output  1  PC source: 1 = PC+immediate, 0 = PC+4
state  output  3  current state (FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5)
trap  output  1  core halted
trap_cause  output  2  0 none, 1 illegal opcode, 2 memory timeout
cycle_count  output  32  see Optional Feature
instret_count  output  32  see Optional Feature

Behaviour:
- Reset: one clock, synchronous, active-high. On any edge with reset=1:
  - state<=FETCH, wait counter<=0, trap_cause<=0.
  - While reset is high, every output is forced to 0, including imem_req.
- Output decoding: outputs are combinational from the state register plus the listed inputs. The state and trap_cause registers update only on the clk rising edge.
- FETCH:
  - imem_req=1.
  - If imem_ready=1: ir_write_en=1 that same cycle, go to DECODE, counter cleared.
  - Otherwise the counter increments. When counter==MEM_TIMEOUT-1 and ready is still low: go to TRAP, cause=2.
- DECODE: one cycle, no strobes. dec_legal=0 goes to TRAP with cause=1; otherwise goes to EXEC.
- EXEC: one cycle.
  - Load or store: go to MEM.
  - Else if dec_write_en: go to WB.
  - Else (branch): pc_write_en=1, pc_sel_branch=branch_taken, go to FETCH.
- MEM:
  - dmem_req=1, dmem_we=dec_mem_write_en.
  - Timeout counting works as in FETCH.
  - On dmem_ready with a load: go to WB.
  - On dmem_ready with a store: pc_write_en=1, go to FETCH.
- WB:
  - rf_write_en=dec_write_en, rf_src_mem=dec_mem_read_en, pc_write_en=1, pc_sel_branch=0.
  - Go to FETCH.
- TRAP: trap=1, all strobes and requests 0, held until reset.
- Ignored inputs: imem_ready outside FETCH and dmem_ready outside MEM are ignored. If both memory-ready flags are high together, only the one matching the current state counts.
- Latency with zero-wait memory (imem_ready/dmem_ready high in the first request cycle):
  - ALU and LUI: 4 cycles.
  - Load: 5 cycles.
  - Store: 4 cycles.
  - Branch: 3 cycles.
  - Each wait cycle adds 1.
- Timeout: MEM_TIMEOUT=0 disables it, so requests wait forever. MEM_TIMEOUT=1 traps if ready is not present in the first request cycle.
- Reset mid-access: the request drops as soon as reset is sampled. The memory side must abandon the access. No PC or RF strobe is issued.

Optional Feature:
- Macro: EKA_PERF_CNT_EN.
- Defined:
  - cycle_count increments every clock after reset, wrapping at 2^32.
  - instret_count increments on every cycle with pc_write_en=1.
  - Both clear on reset and freeze while in TRAP.
- Undefined: both ports are tied to 0 and no counter flops are built.

Test Plan:
- ADDI, zero-wait memory → states 0,1,2,4,0. ir_write_en in cycle 1, rf_write_en and pc_write_en in cycle 4, rf_src_mem=0.
- Load, dmem_ready delayed 3 cycles → MEM held 4 cycles with dmem_req=1 and dmem_we=0. Then WB with rf_src_mem=1. Total 8 cycles.
- Taken branch, then not-taken branch → each retires in 3 cycles. pc_sel_branch=1 then 0. rf_write_en never asserted.
- dec_legal=0 in DECODE → TRAP next cycle, trap=1, trap_cause=1, all strobes 0 for 20 further cycles. Reset returns to FETCH.
- imem_ready held low, MEM_TIMEOUT=16 → imem_req high for exactly 16 cycles, then TRAP with cause=2.
- Reset asserted in MEM mid-store → dmem_req=0 in the reset cycle. state=0 after the edge, no pc_write_en. With EKA_PERF_CNT_EN defined, instret_count=0.
